// File: rtl/module_pc_mem_interface_pkg.sv
// Shared types and constants for the multicycle datapath memory interface.
package pkg_multicycle;

  localparam int unsigned DATA_W           = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } bus_state_e;

  typedef enum logic [1:0] {
    ACC_FETCH = 2'd0,
    ACC_LOAD  = 2'd1,
    ACC_STORE = 2'd2
  } acc_kind_e;

endpackage

// File: rtl/module_pc_mem_interface_timeout.sv
// Wait-cycle counter; tc_o marks the last permitted WAIT cycle before abort.
module module_bus_timeout #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Counter starts at 0 in the first WAIT cycle, so TIMEOUT-1 is the last one.
  assign tc_o = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/module_pc_mem_interface.sv
// PC/OldPC/IR/MDR holder that runs every memory access over a req/ack bus and stalls control meanwhile.
module module_pc_mem_interface
  import pkg_multicycle::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              pcupdate_i,
  input  logic              branch_i,
  input  logic              zero_i,
  input  logic              irwrite_i,
  input  logic              adrsrc_i,
  input  logic              memwrite_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] oldpc_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              stall_o,
  output logic              err_o
);

  bus_state_e        state_q, state_d;
  acc_kind_e         kind_q, kind_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] oldpc_q, oldpc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic acc, stall, req, cnt_clr, cnt_en, cnt_tc, pc_we;

  module_bus_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .tc_o   (cnt_tc)
  );

  assign acc = irwrite_i | memwrite_i | adrsrc_i;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    oldpc_d = oldpc_q;
    instr_d = instr_q;
    data_d  = data_q;
    err_d   = err_q;
    stall   = 1'b0;
    req     = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall = acc;
        if (acc) begin
          addr_d  = adrsrc_i ? result_i : pc_q;
          we_d    = memwrite_i;
          wdata_d = wd_i;
          kind_d  = irwrite_i ? ACC_FETCH : (memwrite_i ? ACC_STORE : ACC_LOAD);
          cnt_clr = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        req    = 1'b1;
        stall  = 1'b1;
        cnt_en = 1'b1;
        // Ack has priority over a coincident timeout and leaves err untouched.
        if (mem_ack_i) begin
          buf_d   = mem_rdata_i;
          state_d = DONE;
        end else if (cnt_tc) begin
          err_d   = 1'b1;
          buf_d   = NOP_INSTR;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        case (kind_q)
          ACC_FETCH: begin
            instr_d = buf_q;
            oldpc_d = pc_q;
          end
          ACC_LOAD: data_d = buf_q;
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch PC update is deferred by the stall until DONE, landing with the IR.
  assign pc_we = (pcupdate_i | (branch_i & zero_i)) & ~stall;
  assign pc_d  = pc_we ? result_i : pc_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      kind_q  <= ACC_LOAD;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      buf_q   <= '0;
      pc_q    <= RESET_PC;
      oldpc_q <= '0;
      instr_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      pc_q    <= pc_d;
      oldpc_q <= oldpc_d;
      instr_q <= instr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign mem_req_o   = req;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign pc_o        = pc_q;
  assign oldpc_o     = oldpc_q;
  assign instr_o     = instr_q;
  assign data_o      = data_q;
  // The IDLE-cycle stall is combinational on the strobes, so mask it during reset.
  assign stall_o     = stall & rst_n_i;
  assign err_o       = err_q;

endmodule
